// File: rtl/mem_align_check_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_align_check_if : MEM-stage alignment checker bus (slot in, flags out)
// Revision 1.0
// ---------------------------------------------------------------------------
interface mem_align_check_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
);
  logic              valid_i;
  logic [5:0]        op_i;
  logic [ADDR_W-1:0] addr_i;
  logic              stall_i;
  logic              flush_i;
  logic              ack_i;
  logic              valid_o;
  logic              adel_o;
  logic              ades_o;
  logic [3:0]        be_o;
  logic [ADDR_W-1:0] badvaddr_o;
  logic              badv_valid_o;
  logic [CNT_W-1:0]  exc_cnt_o;

  modport master (
    output valid_i, op_i, addr_i, stall_i, flush_i, ack_i,
    input  valid_o, adel_o, ades_o, be_o, badvaddr_o, badv_valid_o, exc_cnt_o
  );

  modport slave (
    input  valid_i, op_i, addr_i, stall_i, flush_i, ack_i,
    output valid_o, adel_o, ades_o, be_o, badvaddr_o, badv_valid_o, exc_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/mem_align_check.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_align_check : registered load/store alignment check, byte enables,
//                   sticky BadVAddr capture and saturating fault counter
// Revision 1.0
// ---------------------------------------------------------------------------
module mem_align_check #(
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 8,
  parameter bit STORE_CHECK = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  mem_align_check_if.slave bus
);

  // MIPS I opcode field values
  localparam logic [5:0] c_OP_LB  = 6'h20;
  localparam logic [5:0] c_OP_LH  = 6'h21;
  localparam logic [5:0] c_OP_LW  = 6'h23;
  localparam logic [5:0] c_OP_LBU = 6'h24;
  localparam logic [5:0] c_OP_LHU = 6'h25;
  localparam logic [5:0] c_OP_SB  = 6'h28;
  localparam logic [5:0] c_OP_SH  = 6'h29;
  localparam logic [5:0] c_OP_SW  = 6'h2b;

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]        w_a;
  logic              w_known;
  logic              w_is_load;
  logic              w_is_store;
  logic              w_misalign;
  logic [3:0]        w_be_raw;
  logic              w_adel;
  logic              w_ades;
  logic [3:0]        w_be;
  logic              w_accept;

  logic              r_valid;
  logic              r_adel;
  logic              r_ades;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_badvaddr;
  logic              r_badv_valid;
  logic [CNT_W-1:0]  r_cnt;

  assign w_a = bus.addr_i[1:0];

  always_comb begin
    w_known    = 1'b1;
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_misalign = 1'b0;
    w_be_raw   = 4'b0000;
    case (bus.op_i)
      c_OP_LW, c_OP_SW: begin
        w_is_load  = (bus.op_i == c_OP_LW);
        w_is_store = (bus.op_i == c_OP_SW);
        w_misalign = (w_a != 2'b00);
        w_be_raw   = 4'b1111;
      end
      c_OP_LH, c_OP_LHU, c_OP_SH: begin
        w_is_load  = (bus.op_i != c_OP_SH);
        w_is_store = (bus.op_i == c_OP_SH);
        w_misalign = w_a[0];
        w_be_raw   = w_a[1] ? 4'b1100 : 4'b0011;
      end
      c_OP_LB, c_OP_LBU, c_OP_SB: begin
        w_is_load  = (bus.op_i != c_OP_SB);
        w_is_store = (bus.op_i == c_OP_SB);
        w_be_raw   = 4'b0001 << w_a;
      end
      default: w_known = 1'b0;
    endcase
  end

  // Misaligned stores are suppressed (be 0000) even when they are not flagged
  assign w_adel   = bus.valid_i & w_is_load & w_misalign;
  assign w_ades   = bus.valid_i & w_is_store & w_misalign & STORE_CHECK;
  assign w_be     = (bus.valid_i & w_known & ~w_misalign) ? w_be_raw : 4'b0000;
  assign w_accept = ~bus.flush_i & ~bus.stall_i & (w_adel | w_ades);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_adel  <= 1'b0;
      r_ades  <= 1'b0;
      r_be    <= 4'b0000;
    end else if (bus.flush_i) begin
      r_valid <= 1'b0;
      r_adel  <= 1'b0;
      r_ades  <= 1'b0;
      r_be    <= 4'b0000;
    end else if (!bus.stall_i) begin
      r_valid <= bus.valid_i;
      r_adel  <= w_adel;
      r_ades  <= w_ades;
      r_be    <= w_be;
    end
  end

  // First unacknowledged fault wins; an ack in the same cycle lets a new one in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_badvaddr   <= '0;
      r_badv_valid <= 1'b0;
    end else if (w_accept && (!r_badv_valid || bus.ack_i)) begin
      r_badvaddr   <= bus.addr_i;
      r_badv_valid <= 1'b1;
    end else if (bus.ack_i) begin
      r_badv_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept && (r_cnt != c_CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.valid_o      = r_valid;
  assign bus.adel_o       = r_adel;
  assign bus.ades_o       = r_ades;
  assign bus.be_o         = r_be;
  assign bus.badvaddr_o   = r_badvaddr;
  assign bus.badv_valid_o = r_badv_valid;
  assign bus.exc_cnt_o    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_align_check.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_align_check : scoreboard bench driving three configurations in
//                      lock-step (default, CNT_W=2, STORE_CHECK=0)
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mem_align_check;

  localparam logic [5:0] c_LB = 6'h20, c_LH = 6'h21, c_LW = 6'h23, c_LBU = 6'h24;
  localparam logic [5:0] c_LHU = 6'h25, c_SB = 6'h28, c_SH = 6'h29, c_SW = 6'h2b;
  localparam logic [5:0] c_OPS [10] = '{c_LB, c_LH, c_LW, c_LBU, c_LHU,
                                        c_SB, c_SH, c_SW, 6'h0f, 6'h00};

  typedef struct packed {
    logic        valid;
    logic        adel;
    logic        ades;
    logic [3:0]  be;
    logic [31:0] badv;
    logic        bvalid;
    logic [7:0]  cnt;
  } exp_t;

  typedef struct packed {
    exp_t e0;
    exp_t e1;
    exp_t e2;
  } trio_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        valid = 1'b0;
  logic [5:0]  op    = 6'h00;
  logic [31:0] addr  = 32'h0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ack   = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t  st [3];
  trio_t q [$];

  always #5 clk = ~clk;

  mem_align_check_if #(.ADDR_W(32), .CNT_W(8)) if0 ();
  mem_align_check_if #(.ADDR_W(32), .CNT_W(2)) if1 ();
  mem_align_check_if #(.ADDR_W(32), .CNT_W(8)) if2 ();

  assign if0.valid_i = valid; assign if1.valid_i = valid; assign if2.valid_i = valid;
  assign if0.op_i    = op;    assign if1.op_i    = op;    assign if2.op_i    = op;
  assign if0.addr_i  = addr;  assign if1.addr_i  = addr;  assign if2.addr_i  = addr;
  assign if0.stall_i = stall; assign if1.stall_i = stall; assign if2.stall_i = stall;
  assign if0.flush_i = flush; assign if1.flush_i = flush; assign if2.flush_i = flush;
  assign if0.ack_i   = ack;   assign if1.ack_i   = ack;   assign if2.ack_i   = ack;

  mem_align_check #(.ADDR_W(32), .CNT_W(8), .STORE_CHECK(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mem_align_check #(.ADDR_W(32), .CNT_W(2), .STORE_CHECK(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  mem_align_check #(.ADDR_W(32), .CNT_W(8), .STORE_CHECK(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  // Reference: access size from opcode, alignment by modulo arithmetic
  function automatic exp_t model(input exp_t s, input int inst);
    exp_t n;
    int size, off, cmax;
    bit is_ld, is_st, mis, flt, acc, store_check;
    logic [3:0] be;
    store_check = (inst != 2);
    cmax = (inst == 1) ? 3 : 255;
    size = 0; is_ld = 0; is_st = 0;
    case (op)
      c_LW:         begin size = 4; is_ld = 1; end
      c_SW:         begin size = 4; is_st = 1; end
      c_LH, c_LHU:  begin size = 2; is_ld = 1; end
      c_SH:         begin size = 2; is_st = 1; end
      c_LB, c_LBU:  begin size = 1; is_ld = 1; end
      c_SB:         begin size = 1; is_st = 1; end
      default:      size = 0;
    endcase
    off = int'(addr % 4);
    mis = (size > 0) && ((off % size) != 0);
    flt = valid && mis && (is_ld || (is_st && store_check));
    be  = (valid && size > 0 && !mis) ? 4'(((1 << size) - 1) << off) : 4'b0000;
    n = s;
    if (flush) begin
      n.valid = 0; n.adel = 0; n.ades = 0; n.be = 4'b0000;
    end else if (!stall) begin
      n.valid = valid; n.adel = flt && is_ld; n.ades = flt && is_st; n.be = be;
    end
    acc = !flush && !stall && flt;
    if (acc && (!s.bvalid || ack)) begin
      n.badv = addr; n.bvalid = 1;
    end else if (ack) begin
      n.bvalid = 0;
    end
    if (acc && int'(s.cnt) < cmax) n.cnt = s.cnt + 8'd1;
    return n;
  endfunction

  task automatic compare(input string name, input exp_t e, input exp_t g);
    total++;
    if (e !== g) begin
      bad++;
      $display("FAIL %s cyc=%0d got v=%b adel=%b ades=%b be=%b badv=%h bv=%b cnt=%0d expected v=%b adel=%b ades=%b be=%b badv=%h bv=%b cnt=%0d",
               name, cyc, g.valid, g.adel, g.ades, g.be, g.badv, g.bvalid, g.cnt,
               e.valid, e.adel, e.ades, e.be, e.badv, e.bvalid, e.cnt);
    end
  endtask

  function automatic exp_t got0();
    return {if0.valid_o, if0.adel_o, if0.ades_o, if0.be_o, if0.badvaddr_o, if0.badv_valid_o, if0.exc_cnt_o};
  endfunction
  function automatic exp_t got1();
    return {if1.valid_o, if1.adel_o, if1.ades_o, if1.be_o, if1.badvaddr_o, if1.badv_valid_o, 8'(if1.exc_cnt_o)};
  endfunction
  function automatic exp_t got2();
    return {if2.valid_o, if2.adel_o, if2.ades_o, if2.be_o, if2.badvaddr_o, if2.badv_valid_o, if2.exc_cnt_o};
  endfunction

  // Monitor: outputs are live every cycle, so one entry is consumed per negedge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      trio_t t;
      t = q.pop_front();
      compare("cfg_default", t.e0, got0());
      compare("cfg_cnt2", t.e1, got1());
      compare("cfg_nostorechk", t.e2, got2());
    end
  end

  task automatic step();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 3; i++) st[i] = rst ? exp_t'('0) : model(st[i], i);
    q.push_back({st[0], st[1], st[2]});
    #1;
  endtask

  task automatic apply(input logic v, input logic [5:0] o, input logic [31:0] a,
                       input logic s, input logic f, input logic k);
    valid = v; op = o; addr = a; stall = s; flush = f; ack = k;
    step();
  endtask

  task automatic reset_mid();
    #1 rst = 1'b1;
    #1;
    compare("async_rst_default", exp_t'('0), got0());
    compare("async_rst_cnt2", exp_t'('0), got1());
    compare("async_rst_nostorechk", exp_t'('0), got2());
    for (int i = 0; i < 3; i++) st[i] = '0;
    q.delete();
    q.push_back({st[0], st[1], st[2]});
    apply(0, 6'h00, 32'h0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) st[i] = '0;
    step();
    step();
    rst = 1'b0;

    // Alignment sweep over all opcodes and byte offsets
    for (int k = 0; k < 8; k++)
      for (int a = 0; a < 4; a++)
        apply(1, c_OPS[k], 32'h1000_0000 + 32'(a), 0, 0, 0);
    apply(0, 6'h00, 32'h0, 0, 0, 1);

    // Sticky capture then ack with a concurrent fault
    apply(1, c_LW, 32'h0000_0005, 0, 0, 0);
    apply(1, c_SW, 32'h0000_0006, 0, 0, 0);
    apply(1, c_LH, 32'h0000_0011, 0, 0, 1);
    apply(0, 6'h00, 32'h0, 0, 0, 0);

    // Stall hold, flush beats stall, ack during stall
    apply(1, c_LW, 32'h0000_0021, 1, 0, 0);
    apply(1, c_LW, 32'h0000_0022, 1, 1, 0);
    apply(1, c_SB, 32'h0000_0023, 1, 0, 1);
    apply(1, c_SH, 32'h0000_0026, 0, 0, 0);

    // Async reset with the stage loaded
    apply(1, c_LB, 32'h0000_0003, 0, 0, 0);
    reset_mid();

    // Counter saturation (CNT_W=2 instance) and STORE_CHECK=0 behaviour
    for (int i = 0; i < 5; i++) apply(1, c_LW, 32'h0000_0101 + 32'(4 * i), 0, 0, 0);
    apply(1, c_SW, 32'h1000_0002, 0, 0, 0);
    apply(1, c_LW, 32'h1000_0002, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      apply($urandom_range(7, 0) != 0, c_OPS[$urandom_range(9, 0)], $urandom,
            $urandom_range(7, 0) == 0, $urandom_range(9, 0) == 0, $urandom_range(5, 0) == 0);

    apply(0, 6'h00, 32'h0, 0, 0, 0);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
